// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter with A priority, B starvation guard and B lock
module mem_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    output logic                  a_gnt_o,
    output logic                  a_rvalid_o,
    output logic [DATA_WIDTH-1:0] a_rdata_o,

    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    input  logic                  b_lock_i,
    output logic                  b_gnt_o,
    output logic                  b_rvalid_o,
    output logic [DATA_WIDTH-1:0] b_rdata_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_wr_no,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  locked_o
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;
    localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);

    logic [0:0]            state_q, state_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

    logic a_gnt;
    logic b_gnt;
    logic locked;
    logic starved;

    assign locked  = (state_q == ST_LOCKED);
    assign starved = b_req_i && (starve_cnt_q == STARVE_MAX);

    // Grant decision: lock owner first, then a starved B, then A, then B; nothing during reset
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset_i) begin
            if (locked) begin
                b_gnt = b_req_i;
            end else if (starved) begin
                b_gnt = 1'b1;
            end else if (a_req_i) begin
                a_gnt = 1'b1;
            end else begin
                b_gnt = b_req_i;
            end
        end
    end

    assign a_gnt_o  = a_gnt;
    assign b_gnt_o  = b_gnt;
    assign locked_o = locked;

    // Memory drive: granted port passes straight through, otherwise the last granted values hold
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_wr_no = 1'b1;
        if (a_gnt) begin
            addr_d    = a_addr_i;
            wdata_d   = a_wdata_i;
            mem_wr_no = ~a_we_i;
        end else if (b_gnt) begin
            addr_d    = b_addr_i;
            wdata_d   = b_wdata_i;
            mem_wr_no = ~b_we_i;
        end
    end

    assign mem_addr_o  = addr_d;
    assign mem_wdata_o = wdata_d;

    // Starvation counter: counts A wins while B waits, cleared once B is served or stops asking
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (b_gnt || !b_req_i) begin
            starve_cnt_d = 4'd0;
        end else if (a_gnt && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Lock FSM: a granted B access with lock raised takes ownership, dropping lock releases it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNLOCKED: if (b_gnt && b_lock_i) state_d = ST_LOCKED;
            ST_LOCKED:   if (!b_lock_i)         state_d = ST_UNLOCKED;
        endcase
    end

    // Read return: memory answers one cycle after the grant; rvalid is masked while reset is high
    assign a_rvalid_o = a_rvalid_q & ~reset_i;
    assign b_rvalid_o = b_rvalid_q & ~reset_i;
    assign a_rdata_o  = a_rvalid_o ? mem_rdata_i : a_rdata_q;
    assign b_rdata_o  = b_rvalid_o ? mem_rdata_i : b_rdata_q;

    // Next-state for the read return path
    always_comb begin
        a_rvalid_d = a_gnt & ~a_we_i;
        b_rvalid_d = b_gnt & ~b_we_i;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (a_rvalid_o) a_rdata_d = mem_rdata_i;
        if (b_rvalid_o) b_rdata_d = mem_rdata_i;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_UNLOCKED;
            starve_cnt_q <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o;
    logic [DW-1:0] a_rdata_o, b_rdata_o;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wr_n, locked_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .reset_i(reset),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_lock_i(b_lock),
        .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wr_no(mem_wr_n),
        .mem_rdata_i(mem_rdata), .locked_o(locked_o)
    );

    // Single-port synchronous memory the arbiter drives
    logic [DW-1:0] phys [0:255];
    always @(posedge clk) begin
        if (!mem_wr_n) phys[mem_addr] <= mem_wdata;
        mem_rdata <= phys[mem_addr];
    end

    // Reference model state
    bit            m_locked;
    int            m_starve;
    logic [DW-1:0] m_mem [0:255];
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_a_pend, m_b_pend;
    logic [DW-1:0] m_a_pdata, m_b_pdata, m_a_hold, m_b_hold;

    bit            e_a_gnt, e_b_gnt, e_wr_n, e_a_rv, e_b_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_a_rdata, e_b_rdata;

    task automatic model_clear();
        m_locked = 0; m_starve = 0; m_addr = '0; m_wdata = '0;
        m_a_pend = 0; m_b_pend = 0; m_a_hold = '0; m_b_hold = '0;
        m_a_pdata = '0; m_b_pdata = '0;
    endtask

    task automatic model_eval();
        e_a_gnt = 0;
        e_b_gnt = 0;
        if (!reset) begin
            if (m_locked)                        e_b_gnt = b_req;
            else if (b_req && m_starve == LIMIT) e_b_gnt = 1;
            else if (a_req)                      e_a_gnt = 1;
            else                                 e_b_gnt = b_req;
        end
        e_addr    = e_a_gnt ? a_addr  : (e_b_gnt ? b_addr  : m_addr);
        e_wdata   = e_a_gnt ? a_wdata : (e_b_gnt ? b_wdata : m_wdata);
        e_wr_n    = !((e_a_gnt && a_we) || (e_b_gnt && b_we));
        e_a_rv    = m_a_pend && !reset;
        e_b_rv    = m_b_pend && !reset;
        e_a_rdata = e_a_rv ? m_a_pdata : m_a_hold;
        e_b_rdata = e_b_rv ? m_b_pdata : m_b_hold;
    endtask

    // Advance the model across one clock edge using the inputs that were held during the cycle
    task automatic model_clock();
        model_eval();
        if (reset) begin
            model_clear();
        end else begin
            if (e_a_rv) m_a_hold = m_a_pdata;
            if (e_b_rv) m_b_hold = m_b_pdata;
            m_a_pend = e_a_gnt && !a_we;
            m_b_pend = e_b_gnt && !b_we;
            if (m_a_pend) m_a_pdata = m_mem[a_addr];
            if (m_b_pend) m_b_pdata = m_mem[b_addr];
            if (e_a_gnt && a_we) m_mem[a_addr] = a_wdata;
            if (e_b_gnt && b_we) m_mem[b_addr] = b_wdata;
            if (e_a_gnt || e_b_gnt) begin
                m_addr  = e_addr;
                m_wdata = e_wdata;
            end
            if (e_b_gnt || !b_req) m_starve = 0;
            else if (e_a_gnt)      m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            if (m_locked) m_locked = b_lock;
            else if (e_b_gnt && b_lock) m_locked = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_idle();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        a_req = 1; a_we = 1; a_addr = 8'h33; a_wdata = 16'h5555;
        b_req = 1; b_we = 1; b_addr = 8'h44; b_wdata = 16'h6666; b_lock = 1;
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, b_gnt_o, mem_wr_n} !== 3'b001) begin
            tests_failed++;
            $display("FAIL reset_drive: gnt_a/gnt_b/wr_n got %b want 001", {a_gnt_o, b_gnt_o, mem_wr_n});
        end
        tick();
        tick();
        reset = 0;
        set_idle();
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, b_gnt_o, mem_wr_n, a_rvalid_o, b_rvalid_o, locked_o} !== 6'b001000) begin
            tests_failed++;
            $display("FAIL reset_idle_flags: got %b want 001000",
                     {a_gnt_o, b_gnt_o, mem_wr_n, a_rvalid_o, b_rvalid_o, locked_o});
        end
        tests_run++;
        if ({a_rdata_o, b_rdata_o, mem_addr} !== {DW'(0), DW'(0), AW'(0)}) begin
            tests_failed++;
            $display("FAIL reset_idle_data: a_rdata %h b_rdata %h mem_addr %h want all zero",
                     a_rdata_o, b_rdata_o, mem_addr);
        end
        tick();
    endtask

    task automatic test_write_read();
        do_reset();
        a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 16'hBEEF;
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, b_gnt_o, mem_wr_n, mem_addr, mem_wdata} !== {3'b100, 8'h10, 16'hBEEF}) begin
            tests_failed++;
            $display("FAIL wr_cycle: gnt/wr_n %b addr %h wdata %h want 100 10 beef",
                     {a_gnt_o, b_gnt_o, mem_wr_n}, mem_addr, mem_wdata);
        end
        tick();
        a_we = 0;
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, mem_wr_n, a_rvalid_o, mem_addr} !== {3'b110, 8'h10}) begin
            tests_failed++;
            $display("FAIL rd_cycle: gnt/wr_n/rvalid %b addr %h want 110 10",
                     {a_gnt_o, mem_wr_n, a_rvalid_o}, mem_addr);
        end
        tick();
        set_idle();
        @(negedge clk);
        tests_run++;
        if ({a_rvalid_o, b_rvalid_o, a_rdata_o, mem_wr_n, mem_addr} !== {2'b10, 16'hBEEF, 1'b1, 8'h10}) begin
            tests_failed++;
            $display("FAIL rd_return: rv_a/rv_b %b rdata %h wr_n %b addr %h want 10 beef 1 10",
                     {a_rvalid_o, b_rvalid_o}, a_rdata_o, mem_wr_n, mem_addr);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if ({a_rvalid_o, b_rvalid_o, a_rdata_o, b_rdata_o} !== {2'b00, 16'hBEEF, 16'h0000}) begin
            tests_failed++;
            $display("FAIL rd_hold: rv %b a_rdata %h b_rdata %h want 00 beef 0000",
                     {a_rvalid_o, b_rvalid_o}, a_rdata_o, b_rdata_o);
        end
        tick();
    endtask

    task automatic test_starvation();
        string    seq = "AAAABAAAAB";
        byte      c;
        logic [1:0] want;
        do_reset();
        a_req = 1; a_we = 0; a_addr = 8'h01;
        b_req = 1; b_we = 0; b_addr = 8'h02;
        for (int i = 0; i < 10; i++) begin
            c    = seq[i];
            want = (c == 8'h41) ? 2'b10 : 2'b01;
            @(negedge clk);
            tests_run++;
            if ({a_gnt_o, b_gnt_o} !== want) begin
                tests_failed++;
                $display("FAIL starve_seq[%0d]: gnt_a/gnt_b got %b want %b", i, {a_gnt_o, b_gnt_o}, want);
            end
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        b_req = 1; b_we = 1; b_lock = 1; b_addr = 8'h00; b_wdata = 16'hA000;
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, b_gnt_o, locked_o} !== 3'b010) begin
            tests_failed++;
            $display("FAIL lock_first: gnt_a/gnt_b/locked got %b want 010", {a_gnt_o, b_gnt_o, locked_o});
        end
        tick();
        a_req = 1; a_we = 0; a_addr = 8'h40;
        for (int i = 1; i < 8; i++) begin
            b_addr  = AW'(i);
            b_wdata = 16'hA000 + DW'(i);
            @(negedge clk);
            tests_run++;
            if ({a_gnt_o, b_gnt_o, locked_o, mem_wr_n, mem_addr} !== {4'b0110, AW'(i)}) begin
                tests_failed++;
                $display("FAIL lock_burst[%0d]: gnt_a/gnt_b/locked/wr_n %b addr %h want 0110 %h",
                         i, {a_gnt_o, b_gnt_o, locked_o, mem_wr_n}, mem_addr, i);
            end
            tick();
        end
        b_lock = 0; b_req = 0;
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, b_gnt_o, locked_o} !== 3'b001) begin
            tests_failed++;
            $display("FAIL lock_drop: gnt_a/gnt_b/locked got %b want 001", {a_gnt_o, b_gnt_o, locked_o});
        end
        tick();
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, b_gnt_o, locked_o} !== 3'b100) begin
            tests_failed++;
            $display("FAIL lock_release: gnt_a/gnt_b/locked got %b want 100", {a_gnt_o, b_gnt_o, locked_o});
        end
        tick();
        a_addr = 8'h03;
        tick();
        set_idle();
        @(negedge clk);
        tests_run++;
        if ({a_rvalid_o, a_rdata_o} !== {1'b1, 16'hA003}) begin
            tests_failed++;
            $display("FAIL lock_data: rvalid %b rdata %h want 1 a003", a_rvalid_o, a_rdata_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        a_req = 1; a_we = 1; a_addr = 8'h50; a_wdata = 16'h1234;
        tick();
        a_we = 0;
        tick();
        a_req = 0;
        tick();
        a_req = 1; a_we = 0; a_addr = 8'h50;
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, a_rdata_o} !== {1'b1, 16'h1234}) begin
            tests_failed++;
            $display("FAIL rst_mid_setup: gnt %b held rdata %h want 1 1234", a_gnt_o, a_rdata_o);
        end
        tick();
        reset = 1; a_we = 1; b_req = 1; b_we = 1;
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, b_gnt_o, mem_wr_n, a_rvalid_o} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL rst_mid_suppress: gnt_a/gnt_b/wr_n/rvalid got %b want 0010",
                     {a_gnt_o, b_gnt_o, mem_wr_n, a_rvalid_o});
        end
        tick();
        reset = 0;
        set_idle();
        @(negedge clk);
        tests_run++;
        if ({a_rvalid_o, a_rdata_o, mem_addr, locked_o} !== {1'b0, 16'h0000, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_mid_clear: rvalid %b rdata %h addr %h locked %b want 0 0000 00 0",
                     a_rvalid_o, a_rdata_o, mem_addr, locked_o);
        end
        b_req = 1; b_we = 0; b_lock = 1; b_addr = 8'h50;
        tick();
        b_req = 0;
        reset = 1;
        @(negedge clk);
        tests_run++;
        if (b_rvalid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_lock_rvalid: b_rvalid got %b want 0", b_rvalid_o);
        end
        tick();
        reset = 0;
        @(negedge clk);
        tests_run++;
        if ({locked_o, b_rdata_o} !== {1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL rst_lock_clear: locked %b b_rdata %h want 0 0000", locked_o, b_rdata_o);
        end
        set_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_req = 1; a_we = 1; a_addr = 8'h20; a_wdata = 16'h1111;
        tick();
        a_addr = 8'h21; a_wdata = 16'h2222;
        tick();
        a_we = 0; a_addr = 8'h20;
        @(negedge clk);
        tests_run++;
        if ({a_gnt_o, b_gnt_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b_a_gnt: got %b want 10", {a_gnt_o, b_gnt_o});
        end
        tick();
        a_req = 0; b_req = 1; b_we = 0; b_addr = 8'h21;
        @(negedge clk);
        tests_run++;
        if ({b_gnt_o, a_rvalid_o, b_rvalid_o, a_rdata_o} !== {3'b110, 16'h1111}) begin
            tests_failed++;
            $display("FAIL b2b_first: gnt_b/rv_a/rv_b %b a_rdata %h want 110 1111",
                     {b_gnt_o, a_rvalid_o, b_rvalid_o}, a_rdata_o);
        end
        tick();
        set_idle();
        @(negedge clk);
        tests_run++;
        if ({a_rvalid_o, b_rvalid_o, b_rdata_o, a_rdata_o} !== {2'b01, 16'h2222, 16'h1111}) begin
            tests_failed++;
            $display("FAIL b2b_second: rv_a/rv_b %b b_rdata %h a_rdata %h want 01 2222 1111",
                     {a_rvalid_o, b_rvalid_o}, b_rdata_o, a_rdata_o);
        end
        tick();
    endtask

    task automatic test_random();
        bit a_wait = 0;
        bit b_wait = 0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!a_wait) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_we = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom_range(0, 15));
                a_wdata = DW'($urandom);
            end
            if (!b_wait) begin
                b_req = ($urandom_range(0, 2) != 0);
                b_we = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom_range(0, 15));
                b_wdata = DW'($urandom);
            end
            if ($urandom_range(0, 7) == 0) b_lock = ~b_lock;
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            model_eval();
            tests_run++;
            if ({a_gnt_o, b_gnt_o, mem_wr_n, a_rvalid_o, b_rvalid_o, locked_o} !==
                {e_a_gnt, e_b_gnt, e_wr_n, e_a_rv, e_b_rv, m_locked}) begin
                tests_failed++;
                $display("FAIL rand_ctrl[%0d]: gnt_a/gnt_b/wr_n/rv_a/rv_b/locked got %b want %b", cyc,
                         {a_gnt_o, b_gnt_o, mem_wr_n, a_rvalid_o, b_rvalid_o, locked_o},
                         {e_a_gnt, e_b_gnt, e_wr_n, e_a_rv, e_b_rv, m_locked});
            end
            tests_run++;
            if ({mem_addr, mem_wdata} !== {e_addr, e_wdata}) begin
                tests_failed++;
                $display("FAIL rand_mem[%0d]: addr/wdata got %h/%h want %h/%h", cyc,
                         mem_addr, mem_wdata, e_addr, e_wdata);
            end
            tests_run++;
            if ({a_rdata_o, b_rdata_o} !== {e_a_rdata, e_b_rdata}) begin
                tests_failed++;
                $display("FAIL rand_rdata[%0d]: a/b got %h/%h want %h/%h", cyc,
                         a_rdata_o, b_rdata_o, e_a_rdata, e_b_rdata);
            end
            a_wait = a_req && !e_a_gnt;
            b_wait = b_req && !e_b_gnt;
            tick();
        end
        reset = 0;
        set_idle();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            phys[i]  = '0;
            m_mem[i] = '0;
        end
        model_clear();
        set_idle();
        reset = 1;
        test_reset();
        test_write_read();
        test_starvation();
        test_lock();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
